// File: rtl/max_finder_4bit.sv
// Per-frame peak finder: streams 4-bit samples and reports each frame's maximum and its 0-based position.
// Optional macro TIE_LAST_EN: on equal values the latest position wins (default: earliest position wins).

// state   | meaning
// COLLECT | accepting samples, tracking running max/index
// HOLD    | frame result presented on out_*, waiting for out_ready
module max_finder_4bit #(
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_max,
    output logic [IDX_W-1:0] out_idx
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t           state_q;
    logic [IDX_W-1:0] count_q;
    logic [3:0]       run_max_q;
    logic [IDX_W-1:0] run_idx_q;
    logic [3:0]       out_max_q;
    logic [IDX_W-1:0] out_idx_q;

    logic             accept;
    logic             take;
    logic [3:0]       run_max_d;
    logic [IDX_W-1:0] run_idx_d;

    // First sample of a frame always seeds the running max, whatever was left over.
    always_comb begin
        accept = in_valid && (state_q == COLLECT);
        take   = 1'b0;
        if (count_q == '0) begin
            take = 1'b1;
        end else begin
`ifdef TIE_LAST_EN
            take = (in_data >= run_max_q);
`else
            take = (in_data > run_max_q);
`endif
        end
        run_max_d = take ? in_data : run_max_q;
        run_idx_d = take ? count_q : run_idx_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= COLLECT;
            count_q   <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
            out_max_q <= '0;
            out_idx_q <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        run_max_q <= run_max_d;
                        run_idx_q <= run_idx_d;
                        if (count_q == LAST_IDX) begin
                            count_q   <= '0;
                            out_max_q <= run_max_d;
                            out_idx_q <= run_idx_d;
                            state_q   <= HOLD;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_max_finder_4bit.sv
// Self-checking bench for max_finder_4bit: directed frames plus randomized frames against a queue-based model.
module tb_max_finder_4bit;

    typedef logic [3:0] q4_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, out_ready;
    logic [3:0] in_data;
    logic       in_ready, out_valid;
    logic [3:0] out_max;
    logic [2:0] out_idx;

    logic       a_in_valid, a_out_ready;
    logic [3:0] a_in_data;
    logic       a_in_ready, a_out_valid;
    logic [3:0] a_out_max;
    logic [0:0] a_out_idx;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    max_finder_4bit #(.FRAME_LEN(8), .IDX_W(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_idx(out_idx)
    );

    max_finder_4bit #(.FRAME_LEN(1), .IDX_W(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_max(a_out_max), .out_idx(a_out_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: peak is the queue maximum; position is its first (or last, with ties-to-latest) occurrence.
    function automatic int ref_max(input q4_t s);
        int m = 0;
        foreach (s[i]) if (int'(s[i]) > m) m = int'(s[i]);
        return m;
    endfunction

    function automatic int ref_idx(input q4_t s);
        int m = ref_max(s);
        int idx = -1;
        foreach (s[i]) begin
            if (int'(s[i]) == m) begin
`ifdef TIE_LAST_EN
                idx = i;
`else
                if (idx < 0) idx = i;
`endif
            end
        end
        return idx;
    endfunction

    // gap_mode: 0 none, 1 one idle cycle after every accept, 2 random idle cycles
    task automatic run_frame(input string name, input q4_t s, input int gap_mode, input int hold_cycles);
        int exp_m = ref_max(s);
        int exp_i = ref_idx(s);
        int gaps;
        for (int i = 0; i < s.size(); i++) begin
            gaps = (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_data  = 4'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = s[i];
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s accept%0d: in_ready=%b out_valid=%b required 1/0", name, i, in_ready, out_valid);
            end
            tick();
            if (gap_mode == 1 && i != s.size() - 1) begin
                in_valid = 1'b0;
                in_data  = 4'hF;
                tick();
            end
        end
        in_valid  = 1'b0;
        out_ready = (hold_cycles == 0);
        vectors++;
        if (out_valid !== 1'b1 || out_max !== 4'(exp_m) || out_idx !== 3'(exp_i)) begin
            miscompares++;
            $display("FAIL %s result: valid=%b max=%0d idx=%0d required 1 %0d %0d",
                     name, out_valid, out_max, out_idx, exp_m, exp_i);
        end
        for (int h = 0; h < hold_cycles; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 4'($urandom);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== 4'(exp_m) || out_idx !== 3'(exp_i)) begin
                miscompares++;
                $display("FAIL %s hold%0d: valid=%b ready=%b max=%0d idx=%0d required 1 0 %0d %0d",
                         name, h, out_valid, in_ready, out_max, out_idx, exp_m, exp_i);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b0;
        a_in_valid = 1'b0; a_in_data = 4'h0; a_out_ready = 1'b0;
        tick(); tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_max !== 4'h0 || out_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b ready=%b max=%0d idx=%0d required 0 1 0 0",
                     out_valid, in_ready, out_max, out_idx);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_frame("basic", '{4'd3, 4'd9, 4'd2, 4'd9, 4'd1, 4'd0, 4'd7, 4'd4}, 0, 0);
        run_frame("all_zero", '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 0, 0);
    endtask

    task automatic test_backpressure();
        run_frame("backpressure", '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15}, 0, 5);
    endtask

    task automatic test_gaps();
        run_frame("gaps", '{4'd5, 4'd15, 4'd3, 4'd15, 4'd0, 4'd14, 4'd2, 4'd1}, 1, 0);
    endtask

    task automatic test_reset_midframe();
        q4_t part = '{4'd8, 4'd12, 4'd3, 4'd1};
        foreach (part[i]) begin
            in_valid = 1'b1; in_data = part[i];
            tick();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midframe_async: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        tick();
        reset = 1'b0;
        run_frame("after_reset", '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd6}, 0, 0);
        // reset while a result is pending
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 4'd9;
            tick();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_max !== 4'd0 || out_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_in_hold: valid=%b ready=%b max=%0d idx=%0d required 0 1 0 0",
                     out_valid, in_ready, out_max, out_idx);
        end
        tick();
        reset = 1'b0;
        run_frame("post_hold_reset", '{4'd4, 4'd1, 4'd0, 4'd3, 4'd2, 4'd4, 4'd1, 4'd0}, 0, 0);
    endtask

    task automatic test_frame_len1();
        a_in_valid = 1'b1; a_in_data = 4'd7; a_out_ready = 1'b1;
        vectors++;
        if (a_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL len1_ready: in_ready=%b required 1", a_in_ready);
        end
        tick();
        a_in_data = 4'd4;
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_max !== 4'd7 || a_out_idx !== 1'b0 || a_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL len1_first: valid=%b max=%0d idx=%0d ready=%b required 1 7 0 0",
                     a_out_valid, a_out_max, a_out_idx, a_in_ready);
        end
        tick();
        vectors++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL len1_release: valid=%b ready=%b required 0 1", a_out_valid, a_in_ready);
        end
        tick();
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_max !== 4'd4 || a_out_idx !== 1'b0) begin
            miscompares++;
            $display("FAIL len1_second: valid=%b max=%0d idx=%0d required 1 4 0", a_out_valid, a_out_max, a_out_idx);
        end
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic test_random();
        q4_t s;
        for (int f = 0; f < 40; f++) begin
            s = {};
            for (int i = 0; i < 8; i++) begin
                // narrow value range on some frames to provoke ties
                s.push_back((f % 3 == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom));
            end
            run_frame($sformatf("random%0d", f), s, 2, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_reset_midframe();
        test_frame_len1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
